pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, instruction word inserted into IF/ID as a bubble.
REQ-003 SHALL have port Clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Stall, input, 1, hazard-unit request to freeze the PC and IF/ID.
REQ-006 SHALL have port BranchTaken, input, 1, resolved-taken branch from decode.
REQ-007 SHALL have port BranchTarget, input, 32, branch target byte address.
REQ-008 SHALL have port Jump, input, 1, jump redirect request.
REQ-009 SHALL have port JumpTarget, input, 32, jump target byte address.
REQ-010 SHALL have port Halt, input, 1, stop fetching until Reset.
REQ-011 SHALL have port InstructionIn, input, 32, word returned by instruction memory for IMemAddress.
REQ-012 SHALL have port IMemAddress, output, 32, word index to instruction memory, equal to {22'b0, PC[11:2]}.
REQ-013 SHALL have port PCOut, output, 32, current fetch PC (byte address).
REQ-014 SHALL have port IFID_Instruction, output, 32, registered instruction for decode.
REQ-015 SHALL have port IFID_PCPlus4, output, 32, registered PC+4 of that instruction.
REQ-016 SHALL have port IFID_Valid, output, 1, IFID_Instruction is a real fetched instruction.
REQ-017 SHALL have port FetchCount, output, 32, count of instructions accepted into IF/ID.

Function
REQ-018 SHALL treat instruction memory as combinational: InstructionIn is valid in the same cycle as IMemAddress.
REQ-019 SHALL implement FSM states RUN, STALLED, and HALTED, with RUN entered on Reset.
REQ-020 SHALL apply next-PC priority per cycle: Reset > BranchTaken > Jump > Halt > Stall > PC+4.
REQ-021 SHALL, on BranchTaken or Jump, load PC with the target with bits [1:0] forced to 0, load IF/ID with NOP_INSTR and Valid=0, hold FetchCount, and go to RUN; this applies regardless of Stall.
REQ-022 SHALL, on Stall alone (in RUN or STALLED), hold PC, IF/ID and FetchCount, and be in STALLED.
REQ-023 SHALL, in STALLED with Stall deasserted, return to RUN and resume the sequential update in that same cycle.
REQ-024 SHALL, on the sequential update, set PC<=PC+4, IFID_Instruction<=InstructionIn, IFID_PCPlus4<=PC+4, IFID_Valid<=1, and FetchCount<=FetchCount+1.
REQ-025 SHALL, on Halt without redirect, enter HALTED; HALTED holds PC, bubbles IF/ID (NOP_INSTR, Valid=0), ignores Stall/Branch/Jump, and exits only on Reset.
REQ-026 SHALL compute PC+4 modulo 2^32: 32'hFFFF_FFFC wraps to 0, and IMemAddress wraps from 1023 to 0.
REQ-027 SHALL compute FetchCount modulo 2^32, with no saturation.
REQ-028 SHALL drive IMemAddress and PCOut combinationally from the PC register only, never from the inputs.

Reset
REQ-029 SHALL, on Reset asserted at the clock edge, set PC=RESET_PC, IFID_Instruction=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0, and state=RUN.
REQ-030 SHALL let Reset override every other input in every state, including HALTED and mid-stall.
REQ-031 SHALL leave no output undefined after the first Reset edge.

Structure
REQ-032 SHALL place the FSM state encoding, NOP_INSTR default, and the PC increment constant (4) in a shared package used by later pipeline stages.
REQ-033 SHALL implement the IF/ID register as the sub-module ifid_register (inputs: load, flush; 65-bit payload).
REQ-034 SHALL keep the next-PC mux and FSM in the top module.

Verification
REQ-035 SHALL verify reset then 3 free-running cycles: PCOut 0->4->8->12; IFID_PCPlus4=4,8,12; FetchCount=3; IFID_Valid=1 from cycle 1.
REQ-036 SHALL verify Stall held 2 cycles at PC=8: PC stays 8, IF/ID unchanged, FetchCount unchanged; after release PC=12 in the next cycle.
REQ-037 SHALL verify BranchTaken=1 with Stall=1 and BranchTarget=32'h0000_0043: PC=32'h40 next cycle, IFID_Valid=0, IFID_Instruction=NOP_INSTR.
REQ-038 SHALL verify BranchTaken and Jump together (targets 32'h100, 32'h200): PC=32'h100.
REQ-039 SHALL verify PC=32'hFFC: IMemAddress=1023, then PC=32'h1000 gives IMemAddress=0; PC=32'hFFFF_FFFC advances to 0.
REQ-040 SHALL verify Halt at PC=32'h20: PC stays 32'h20 and IFID_Valid=0 despite a Jump; Reset then gives PC=RESET_PC and state RUN.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the later pipeline stages that consume IF/ID.
//   fetch_state_e    : fetch FSM state encoding (run / stalled / halted)
//   NopInstrDefault  : default bubble instruction word
//   PcIncrement      : sequential PC step in bytes
//   ifid_payload_t   : 65-bit IF/ID payload {instr, pc_plus4, valid}
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StStalled = 2'd1,
        StHalted  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NopInstrDefault = 32'h0000_0000;
    localparam logic [31:0] PcIncrement     = 32'd4;

    localparam int unsigned IfidPayloadWidth = 65;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_payload_t;

    // Redirect targets are byte addresses; fetch is always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control, instruction-memory and IF/ID signals of the fetch stage.
//   master : pipeline/hazard side - drives redirect, stall, halt and the memory read data
//   slave  : fetch unit side      - drives the memory address, PC and IF/ID outputs
interface pc_fetch_unit_if;

    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Halt;
    logic [31:0] InstructionIn;
    logic [31:0] IMemAddress;
    logic [31:0] PCOut;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [31:0] FetchCount;

    modport master (
        output Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Halt, InstructionIn,
        input  IMemAddress, PCOut, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Halt, InstructionIn,
        output IMemAddress, PCOut, IFID_Instruction, IFID_PCPlus4, IFID_Valid, FetchCount
    );

endinterface

// File: rtl/ifid_register.sv
// IF/ID pipeline register.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : capture payload_i
//   flush_i      : replace contents with a bubble (wins over load_i)
//   payload_i/o  : 65-bit {instr, pc_plus4, valid}
module ifid_register
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] NopInstr = NopInstrDefault
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        load_i,
    input  logic                        flush_i,
    input  logic [IfidPayloadWidth-1:0] payload_i,
    output logic [IfidPayloadWidth-1:0] payload_o
);

    localparam logic [IfidPayloadWidth-1:0] Bubble = {NopInstr, 32'h0000_0000, 1'b0};

    logic [IfidPayloadWidth-1:0] payload_d, payload_q;

    always_comb begin
        payload_d = payload_q;
        if (flush_i) begin
            payload_d = Bubble;
        end else if (load_i) begin
            payload_d = payload_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            payload_q <= Bubble;
        end else begin
            payload_q <= payload_d;
        end
    end

    assign payload_o = payload_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, fetch FSM and IF/ID register.
//   Clk   : clock, all state updates on the rising edge
//   Reset : synchronous active-high reset, overrides everything
//   bus   : slave side of pc_fetch_unit_if (redirects, stall, halt, imem port, IF/ID outputs)
// Next-PC priority: Reset > BranchTaken > Jump > Halt > Stall > PC+4. Halted ignores all but Reset.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NopInstrDefault
) (
    input  logic                 Clk,
    input  logic                 Reset,
    pc_fetch_unit_if.slave       bus
);

    fetch_state_e  state_d, state_q;
    logic [31:0]   pc_d, pc_q;
    logic [31:0]   count_d, count_q;
    logic [31:0]   pc_plus4;
    logic          ifid_load;
    logic          ifid_flush;
    ifid_payload_t ifid_in;
    ifid_payload_t ifid_out;

    assign pc_plus4 = pc_q + PcIncrement;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;

        if (state_q == StHalted) begin
            // Halted keeps the PC and keeps bubbling decode until Reset.
            ifid_flush = 1'b1;
        end else if (bus.BranchTaken) begin
            pc_d       = align_word(bus.BranchTarget);
            ifid_flush = 1'b1;
            state_d    = StRun;
        end else if (bus.Jump) begin
            pc_d       = align_word(bus.JumpTarget);
            ifid_flush = 1'b1;
            state_d    = StRun;
        end else if (bus.Halt) begin
            ifid_flush = 1'b1;
            state_d    = StHalted;
        end else if (bus.Stall) begin
            state_d = StStalled;
        end else begin
            // Leaving a stall resumes sequential fetch in the same cycle.
            pc_d      = pc_plus4;
            count_d   = count_q + 32'd1;
            ifid_load = 1'b1;
            state_d   = StRun;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StRun;
            pc_q    <= RESET_PC;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    assign ifid_in.instr    = bus.InstructionIn;
    assign ifid_in.pc_plus4 = pc_plus4;
    assign ifid_in.valid    = 1'b1;

    ifid_register #(
        .NopInstr (NOP_INSTR)
    ) u_ifid_register (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .load_i    (ifid_load),
        .flush_i   (ifid_flush),
        .payload_i (ifid_in),
        .payload_o (ifid_out)
    );

    assign bus.IMemAddress      = {22'b0, pc_q[11:2]};
    assign bus.PCOut            = pc_q;
    assign bus.IFID_Instruction = ifid_out.instr;
    assign bus.IFID_PCPlus4     = ifid_out.pc_plus4;
    assign bus.IFID_Valid       = ifid_out.valid;
    assign bus.FetchCount       = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] TbResetPc = 32'h0000_0000;
    localparam logic [31:0] TbNop     = 32'h0000_0013;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_errors;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC  (TbResetPc),
        .NOP_INSTR (TbNop)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Instruction memory: combinational, contents are a fixed scramble of the word index.
    function automatic logic [31:0] imem(input logic [31:0] word_idx);
        return 32'hC0DE_0000 ^ (word_idx * 32'h9E37_79B1);
    endfunction

    assign bus.InstructionIn = imem(bus.IMemAddress);

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_instr, m_pcp4, m_count;
    logic        m_valid, m_halted;

    function void model_step();
        logic [31:0] word;
        word = {22'b0, m_pc[11:2]};
        if (Reset) begin
            m_pc = TbResetPc; m_instr = TbNop; m_pcp4 = 32'd0; m_valid = 1'b0;
            m_count = 32'd0; m_halted = 1'b0;
        end else if (m_halted) begin
            m_instr = TbNop; m_valid = 1'b0;
        end else if (bus.BranchTaken || bus.Jump) begin
            m_pc    = (bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget) & 32'hFFFF_FFFC;
            m_instr = TbNop; m_valid = 1'b0;
        end else if (bus.Halt) begin
            m_halted = 1'b1; m_instr = TbNop; m_valid = 1'b0;
        end else if (!bus.Stall) begin
            m_instr = imem(word);
            m_pcp4  = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("pc", bus.PCOut, m_pc);
        check("imem_addr", bus.IMemAddress, {22'b0, m_pc[11:2]});
        check("ifid_instr", bus.IFID_Instruction, m_instr);
        check("ifid_valid", {31'b0, bus.IFID_Valid}, {31'b0, m_valid});
        check("fetch_count", bus.FetchCount, m_count);
        if (m_valid) check("ifid_pcp4", bus.IFID_PCPlus4, m_pcp4);
    endtask

    task automatic apply(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt, input bit h);
        @(negedge Clk);
        Reset            = rst;
        bus.Stall        = st;
        bus.BranchTaken  = br;
        bus.BranchTarget = bt;
        bus.Jump         = j;
        bus.JumpTarget   = jt;
        bus.Halt         = h;
        @(posedge Clk);
        model_step();
        #1;
        compare_model();
    endtask

    typedef struct {
        bit          rst, st, br;
        logic [31:0] bt;
        bit          j;
        logic [31:0] jt;
        bit          h;
        logic [31:0] exp_pc;
        logic [31:0] exp_imem;
        bit          exp_valid;
        logic [31:0] exp_count;
    } vec_t;

    function automatic vec_t mk(bit rst, bit st, bit br, logic [31:0] bt, bit j,
                                logic [31:0] jt, bit h, logic [31:0] pc, logic [31:0] ia,
                                bit v, logic [31:0] c);
        vec_t r;
        r.rst = rst; r.st = st; r.br = br; r.bt = bt; r.j = j; r.jt = jt; r.h = h;
        r.exp_pc = pc; r.exp_imem = ia; r.exp_valid = v; r.exp_count = c;
        return r;
    endfunction

    localparam int NumVecs = 23;
    vec_t vecs[NumVecs];

    initial begin
        n_checks = 0;
        n_errors = 0;
        Reset = 1'b1;
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
        bus.Jump = 1'b0; bus.JumpTarget = '0; bus.Halt = 1'b0;

        //              rst st br bt            j  jt            h  pc            imem  v  cnt
        vecs[0]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0,    0, 0);
        vecs[1]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         1,    1, 1);
        vecs[2]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         2,    1, 2);
        vecs[3]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hC,         3,    1, 3);
        vecs[4]  = mk(1, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0,    0, 0);
        vecs[5]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         1,    1, 1);
        vecs[6]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h8,         2,    1, 2);
        vecs[7]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         2,    1, 2);
        vecs[8]  = mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h8,         2,    1, 2);
        vecs[9]  = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'hC,         3,    1, 3);
        vecs[10] = mk(0, 1, 1, 32'h43,        0, 32'h0,         0, 32'h40,        16,   0, 3);
        vecs[11] = mk(0, 0, 1, 32'h100,       1, 32'h200,       0, 32'h100,       64,   0, 3);
        vecs[12] = mk(0, 0, 0, 32'h0,         1, 32'hFFC,       0, 32'hFFC,       1023, 0, 3);
        vecs[13] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h1000,      0,    1, 4);
        vecs[14] = mk(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1023, 0, 4);
        vecs[15] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0,    1, 5);
        vecs[16] = mk(0, 0, 0, 32'h0,         1, 32'h20,        0, 32'h20,        8,    0, 5);
        vecs[17] = mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h20,        8,    0, 5);
        vecs[18] = mk(0, 0, 0, 32'h0,         1, 32'h80,        0, 32'h20,        8,    0, 5);
        vecs[19] = mk(0, 1, 1, 32'h90,        0, 32'h0,         0, 32'h20,        8,    0, 5);
        vecs[20] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h20,        8,    0, 5);
        vecs[21] = mk(1, 0, 0, 32'h0,         1, 32'h300,       1, 32'h0,         0,    0, 0);
        vecs[22] = mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h4,         1,    1, 1);

        for (int i = 0; i < NumVecs; i++) begin
            apply(vecs[i].rst, vecs[i].st, vecs[i].br, vecs[i].bt, vecs[i].j, vecs[i].jt,
                  vecs[i].h);
            check($sformatf("vec%0d_pc", i), bus.PCOut, vecs[i].exp_pc);
            check($sformatf("vec%0d_imem", i), bus.IMemAddress, vecs[i].exp_imem);
            check($sformatf("vec%0d_valid", i), {31'b0, bus.IFID_Valid},
                  {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_count", i), bus.FetchCount, vecs[i].exp_count);
        end

        // Reset in the middle of a stall, then a stall released straight into a branch.
        apply(0, 1, 0, 32'h0, 0, 32'h0, 0);
        apply(1, 1, 0, 32'h0, 0, 32'h0, 0);
        check("reset_mid_stall_pc", bus.PCOut, TbResetPc);
        apply(0, 0, 0, 32'h0, 0, 32'h0, 0);
        apply(0, 1, 0, 32'h0, 0, 32'h0, 0);
        apply(0, 0, 1, 32'h0000_0A5E, 0, 32'h0, 0);
        check("branch_after_stall_pc", bus.PCOut, 32'h0000_0A5C);

        // Randomized traffic checked against the model every cycle.
        for (int n = 0; n < 600; n++) begin
            apply($urandom_range(0, 29) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 7) == 0, $urandom,
                  $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
